// File: rtl/control_unit_pkg.sv
// control_unit_pkg
//   Shared definitions for param_control_unit:
//   - opcode values (OP_NOP .. OP_END)
//   - FSM state encoding
//   - instruction field offsets as functions of IW/OPW/DW/SW.
//   Instruction layout, MSB first: {op[OPW], dst[DW], src[SW], aux[rest]}.
package control_unit_pkg;

  localparam int OP_NOP   = 0;
  localparam int OP_MOVE  = 1;
  localparam int OP_LOAD  = 2;
  localparam int OP_STORE = 3;
  localparam int OP_INC   = 4;
  localparam int OP_ALU   = 5;
  localparam int OP_JZ    = 6;
  localparam int OP_JNZ   = 7;
  localparam int OP_END   = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_MEMW   = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  function automatic int op_lsb(input int iw, input int opw);
    return iw - opw;
  endfunction

  function automatic int dst_lsb(input int iw, input int opw, input int dw);
    return iw - opw - dw;
  endfunction

  // The aux field occupies everything below src, so its width equals src_lsb.
  function automatic int src_lsb(input int iw, input int opw, input int dw, input int sw);
    return iw - opw - dw - sw;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// onehot_decoder
//   Turns a binary index into an N-bit one-hot vector.
//   Ports:
//     idx_i     in  XW  binary index
//     en_i      in  1   produce a one-hot bit this cycle
//     onehot_o  out N   one-hot result; all zero when disabled or out of range
//     oor_o     out 1   idx_i >= N (independent of en_i, so the caller decides
//                       whether an out-of-range index matters)
module onehot_decoder #(
  parameter int N  = 4,
  parameter int XW = 2
) (
  input  logic [XW-1:0] idx_i,
  input  logic          en_i,
  output logic [N-1:0]  onehot_o,
  output logic          oor_o
);

  // One extra bit so N itself is representable when N == 2**XW.
  localparam logic [XW:0] N_L = (XW + 1)'(N);

  always_comb begin
    oor_o    = ({1'b0, idx_i} >= N_L);
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      onehot_o[i] = en_i && !oor_o && (idx_i == i[XW-1:0]);
    end
  end

endmodule

// File: rtl/param_control_unit.sv
// param_control_unit
//   Multicycle control FSM for the matrix-multiplication datapath.
//   IDLE -> FETCH -> DECODE -> EXEC -> (WB | MEMW | HALT | FETCH).
//   Handshakes: instr_valid is only looked at in FETCH; the word is captured
//   into IR on the edge where it is high. mem_ready is only looked at in MEMW;
//   the access completes on the edge where it is high, and a LOAD writes its
//   destination only in that cycle.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     start             leave IDLE/HALT and begin fetching
//     instr/instr_valid instruction word and its valid
//     Z                 ALU zero flag, used by JZ/JNZ in EXEC
//     mem_ready         completes the current memory access
//     fetch             instruction request (FETCH)
//     mem_req/mem_we    data memory access pending / is a write
//     write_enable      one-hot register load (NREG)
//     read_enable       one-hot bus source (NSRC)
//     increment         increment strobes, bit 0 = PC+1
//     alu               ALU operation
//     finish            program ended (HALT)
//     illegal           one-cycle flag in EXEC: bad opcode or out-of-range index
//     dbg_state_o       current FSM state
module param_control_unit
  import control_unit_pkg::*;
#(
  parameter int IW     = 16,
  parameter int OPW    = 4,
  parameter int NREG   = 17,
  parameter int NSRC   = 5,
  parameter int NINC   = 7,
  parameter int ALUW   = 3,
  parameter int PC_IDX = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IW-1:0]   instr,
  input  logic            instr_valid,
  input  logic            Z,
  input  logic            mem_ready,
  output logic            fetch,
  output logic            mem_req,
  output logic            mem_we,
  output logic [NREG-1:0] write_enable,
  output logic [NSRC-1:0] read_enable,
  output logic [NINC-1:0] increment,
  output logic [ALUW-1:0] alu,
  output logic            finish,
  output logic            illegal,
  output logic [2:0]      dbg_state_o
);

  localparam int DW      = $clog2(NREG);
  localparam int SW      = $clog2(NSRC);
  localparam int OP_LSB  = op_lsb(IW, OPW);
  localparam int DST_LSB = dst_lsb(IW, OPW, DW);
  localparam int SRC_LSB = src_lsb(IW, OPW, DW, SW);
  localparam int AUXW    = SRC_LSB;

  localparam logic [OPW-1:0] K_NOP   = OPW'(OP_NOP);
  localparam logic [OPW-1:0] K_MOVE  = OPW'(OP_MOVE);
  localparam logic [OPW-1:0] K_LOAD  = OPW'(OP_LOAD);
  localparam logic [OPW-1:0] K_STORE = OPW'(OP_STORE);
  localparam logic [OPW-1:0] K_INC   = OPW'(OP_INC);
  localparam logic [OPW-1:0] K_ALU   = OPW'(OP_ALU);
  localparam logic [OPW-1:0] K_JZ    = OPW'(OP_JZ);
  localparam logic [OPW-1:0] K_JNZ   = OPW'(OP_JNZ);
  localparam logic [OPW-1:0] K_END   = OPW'(OP_END);

  state_e          state_q, state_d;
  logic [IW-1:0]   ir_q, ir_d;

  logic [OPW-1:0]  op_f;
  logic [DW-1:0]   dst_f;
  logic [SW-1:0]   src_f;
  logic [AUXW-1:0] aux_f;

  assign op_f  = ir_q[OP_LSB +: OPW];
  assign dst_f = ir_q[DST_LSB +: DW];
  assign src_f = ir_q[SRC_LSB +: SW];
  assign aux_f = ir_q[0 +: AUXW];

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (op_f == K_LOAD || op_f == K_STORE) state_d = S_MEMW;
        else if (op_f == K_ALU)                state_d = S_WB;
        else if (op_f == K_END)                state_d = S_HALT;
        else                                   state_d = S_FETCH;
      end
      S_WB:     state_d = S_FETCH;
      S_MEMW:   if (mem_ready) state_d = S_FETCH;
      S_HALT:   if (start) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------- decode
  logic            in_exec, in_wb, in_memw;
  logic            is_jump, jump_taken, uses_dst, uses_src, op_known;
  logic [DW-1:0]   wr_idx;
  logic            wr_en, rd_en, inc_en;
  logic            wr_oor, rd_oor, inc_oor;
  logic [NINC-1:0] inc_oh;

  always_comb begin
    in_exec    = (state_q == S_EXEC);
    in_wb      = (state_q == S_WB);
    in_memw    = (state_q == S_MEMW);
    is_jump    = (op_f == K_JZ) || (op_f == K_JNZ);
    jump_taken = ((op_f == K_JZ) && Z) || ((op_f == K_JNZ) && !Z);
    uses_dst   = (op_f == K_MOVE) || (op_f == K_LOAD) || (op_f == K_ALU);
    uses_src   = (op_f == K_MOVE) || (op_f == K_STORE) || (op_f == K_ALU) || is_jump;
    op_known   = (op_f <= K_END);

    // A taken jump loads the PC; every other write targets dst.
    wr_idx = (in_exec && is_jump) ? DW'(PC_IDX) : dst_f;

    // rst gates the LOAD completion write so a reset coinciding with
    // mem_ready never commits data.
    wr_en  = (in_exec && ((op_f == K_MOVE) || jump_taken))
          || in_wb
          || (in_memw && (op_f == K_LOAD) && mem_ready && !rst);
    rd_en  = (in_exec && ((op_f == K_MOVE) || (op_f == K_ALU) || jump_taken))
          || (in_memw && (op_f == K_STORE));
    inc_en = in_exec && (op_f == K_INC);
  end

  onehot_decoder #(.N(NREG), .XW(DW)) u_wr_dec (
    .idx_i(wr_idx), .en_i(wr_en), .onehot_o(write_enable), .oor_o(wr_oor)
  );

  onehot_decoder #(.N(NSRC), .XW(SW)) u_rd_dec (
    .idx_i(src_f), .en_i(rd_en), .onehot_o(read_enable), .oor_o(rd_oor)
  );

  onehot_decoder #(.N(NINC), .XW(AUXW)) u_inc_dec (
    .idx_i(aux_f), .en_i(inc_en), .onehot_o(inc_oh), .oor_o(inc_oor)
  );

  // -------------------------------------------------------------- outputs
  always_comb begin
    fetch     = (state_q == S_FETCH);
    mem_req   = in_memw;
    mem_we    = in_memw && (op_f == K_STORE);
    finish    = (state_q == S_HALT);
    increment = inc_oh | {{(NINC-1){1'b0}}, (state_q == S_DECODE)};
    alu       = '0;
    if ((in_exec && (op_f == K_ALU)) || in_wb) alu = aux_f[ALUW-1:0];
    illegal   = in_exec && (!op_known
                         || (uses_dst && wr_oor)
                         || (uses_src && rd_oor)
                         || ((op_f == K_INC) && inc_oor));
    dbg_state_o = state_q;
  end

  // NOP needs no decode of its own; it simply returns to FETCH.
  logic unused_nop;
  assign unused_nop = (op_f == K_NOP);

endmodule

// File: tb/tb_param_control_unit.sv
// Bench for param_control_unit with the default parameters
// (IW=16, OPW=4, NREG=17, NSRC=5, NINC=7, ALUW=3, PC_IDX=0).
module tb_param_control_unit;

  localparam int W = 37;

  // ------------------------------------------------ clock / reset / DUT
  logic        clk = 1'b0;
  logic        rst, start, instr_valid, Z, mem_ready;
  logic [15:0] instr;
  logic        fetch, mem_req, mem_we, finish, illegal;
  logic [16:0] write_enable;
  logic [4:0]  read_enable;
  logic [6:0]  increment;
  logic [2:0]  alu;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  param_control_unit dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr),
    .instr_valid(instr_valid), .Z(Z), .mem_ready(mem_ready),
    .fetch(fetch), .mem_req(mem_req), .mem_we(mem_we),
    .write_enable(write_enable), .read_enable(read_enable),
    .increment(increment), .alu(alu), .finish(finish),
    .illegal(illegal), .dbg_state_o(dbg_state)
  );

  // ------------------------------------------------ scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  function automatic logic [W-1:0] pack_obs();
    return {fetch, mem_req, mem_we, write_enable, read_enable, increment, alu, finish, illegal};
  endfunction

  function automatic logic [W-1:0] ev(input logic f, input logic mreq, input logic mwe,
                                      input logic [16:0] we, input logic [4:0] re,
                                      input logic [6:0] inc, input logic [2:0] a,
                                      input logic fin, input logic ill);
    return {f, mreq, mwe, we, re, inc, a, fin, ill};
  endfunction

  function automatic logic [15:0] mk(input int op, input int dst, input int src, input int aux);
    return {op[3:0], dst[4:0], src[2:0], aux[3:0]};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // ------------------------------------------------ reference model
  // Expected per-cycle outputs for one instruction, starting at its first
  // FETCH cycle. extra = cycles after EXEC; mem = those cycles are a memory wait.
  task automatic model_instr(input int stall, input logic [15:0] ins, input logic z,
                             input int waits, output int extra, output logic mem);
    int op, dst, src, aux;
    logic [16:0] dst_oh, we;
    logic [4:0]  src_oh, re;
    logic [6:0]  inc;
    logic [2:0]  a;
    logic        ill, taken;
    op  = int'(ins >> 12);
    dst = int'((ins >> 7) & 16'd31);
    src = int'((ins >> 4) & 16'd7);
    aux = int'(ins & 16'd15);
    dst_oh = (dst < 17) ? (17'd1 << dst) : 17'd0;
    src_oh = (src < 5) ? (5'd1 << src) : 5'd0;
    we = '0; re = '0; inc = '0; a = '0; ill = 1'b0;
    extra = 0; mem = 1'b0;
    for (int i = 0; i < stall; i++) exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 0, 7'd1, 0, 0, 0));
    case (op)
      0: ;
      1: begin we = dst_oh; re = src_oh; ill = (dst >= 17) || (src >= 5); end
      2: ill = (dst >= 17);
      3: ill = (src >= 5);
      4: begin inc = (aux < 7) ? (7'd1 << aux) : 7'd0; ill = (aux >= 7); end
      5: begin re = src_oh; a = 3'(aux % 8); ill = (dst >= 17) || (src >= 5); end
      6, 7: begin
        taken = (op == 6) ? z : !z;
        if (taken) begin we = 17'd1; re = src_oh; end
        ill = (src >= 5);
      end
      8: ;
      default: ill = 1'b1;
    endcase
    exp_q.push_back(ev(0, 0, 0, we, re, inc, a, 0, ill));
    if (op == 5) begin
      exp_q.push_back(ev(0, 0, 0, dst_oh, 0, 0, 3'(aux % 8), 0, 0));
      extra = 1;
    end else if (op == 2) begin
      for (int i = 0; i < waits; i++) exp_q.push_back(ev(0, 1, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(ev(0, 1, 0, dst_oh, 0, 0, 0, 0, 0));
      extra = waits + 1; mem = 1'b1;
    end else if (op == 3) begin
      for (int i = 0; i <= waits; i++) exp_q.push_back(ev(0, 1, 1, 0, src_oh, 0, 0, 0, 0));
      extra = waits + 1; mem = 1'b1;
    end
  endtask

  // ------------------------------------------------ driver tasks
  // Drive one cycle's inputs at the falling edge and sample outputs 1ns later.
  task automatic cycle(input logic r, input logic s, input logic v, input logic [15:0] ins,
                       input logic z, input logic rdy);
    @(negedge clk);
    rst = r; start = s; instr_valid = v; instr = ins; Z = z; mem_ready = rdy;
    #1;
    obs_q.push_back(pack_obs());
  endtask

  // Irrelevant inputs (start, instr_valid outside FETCH, Z outside EXEC,
  // mem_ready outside the memory wait) are randomised on purpose.
  task automatic drive_instr(input int stall, input logic [15:0] ins, input logic z,
                             input int extra, input logic mem);
    for (int i = 0; i < stall; i++) cycle(0, rb(), 0, 16'($urandom), rb(), rb());
    cycle(0, rb(), 1, ins, rb(), rb());
    cycle(0, rb(), rb(), 16'($urandom), rb(), rb());
    cycle(0, rb(), rb(), 16'($urandom), z, rb());
    for (int k = 0; k < extra; k++)
      cycle(0, rb(), rb(), 16'($urandom), rb(), mem ? (k == extra - 1) : rb());
  endtask

  task automatic run_instr(input int stall, input logic [15:0] ins, input logic z, input int waits);
    int extra;
    logic mem;
    model_instr(stall, ins, z, waits, extra, mem);
    drive_instr(stall, ins, z, extra, mem);
  endtask

  // ------------------------------------------------ tests
  task automatic test_reset();
    logic [W-1:0] e, o;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    obs_q.delete(); exp_q.delete();
    cycle(0, 0, 0, 0, 0, 0);            exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle(0, 1, 0, 0, 0, 0);            exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle(0, 0, 1, mk(2, 4, 0, 0), 0, 0); exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle(0, 0, 0, 0, 0, 0);            exp_q.push_back(ev(0, 0, 0, 0, 0, 7'd1, 0, 0, 0));
    cycle(0, 0, 0, 0, 0, 0);            exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle(0, 0, 0, 0, 0, 0);            exp_q.push_back(ev(0, 1, 0, 0, 0, 0, 0, 0, 0));
    cycle(1, 0, 0, 0, 0, 1);            exp_q.push_back(ev(0, 1, 0, 0, 0, 0, 0, 0, 0));
    cycle(0, 1, 0, 0, 0, 0);            exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle(0, 0, 0, 0, 0, 0);            exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL reset cyc%0d got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_move();
    logic [W-1:0] e, o;
    obs_q.delete(); exp_q.delete();
    run_instr(0, mk(1, 3, 2, 0), 0, 0);
    run_instr(1, mk(0, 0, 0, 0), 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL move cyc%0d got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_alu();
    logic [W-1:0] e, o;
    obs_q.delete(); exp_q.delete();
    run_instr(0, mk(5, 6, 1, 5), 0, 0);
    run_instr(0, mk(5, 16, 4, 2), 1, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL alu cyc%0d got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_memory();
    logic [W-1:0] e, o;
    obs_q.delete(); exp_q.delete();
    run_instr(0, mk(2, 9, 0, 0), 0, 3);
    run_instr(0, mk(3, 0, 4, 0), 0, 2);
    run_instr(0, mk(2, 1, 0, 0), 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL memory cyc%0d got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_jump();
    logic [W-1:0] e, o;
    obs_q.delete(); exp_q.delete();
    run_instr(0, mk(6, 0, 3, 0), 1, 0);
    run_instr(0, mk(6, 0, 3, 0), 0, 0);
    run_instr(0, mk(7, 0, 1, 0), 0, 0);
    run_instr(0, mk(7, 0, 1, 0), 1, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL jump cyc%0d got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_illegal_halt();
    logic [W-1:0] e, o;
    obs_q.delete(); exp_q.delete();
    run_instr(0, mk(15, 0, 0, 0), 0, 0);
    run_instr(0, mk(1, 20, 2, 0), 0, 0);
    run_instr(0, mk(4, 0, 0, 9), 0, 0);
    run_instr(0, mk(4, 0, 0, 6), 0, 0);
    run_instr(0, mk(8, 0, 0, 0), 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, rb(), 16'($urandom), rb(), rb());
      exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 1, 0));
    end
    cycle(0, 1, 0, 0, 0, 0);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 1, 0));
    run_instr(0, mk(0, 0, 0, 0), 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL illegal_halt cyc%0d got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_random(input int n);
    logic [W-1:0] e, o;
    int op;
    obs_q.delete(); exp_q.delete();
    for (int t = 0; t < n; t++) begin
      op = $urandom_range(0, 8);
      if (op == 8) op = $urandom_range(9, 15);
      run_instr($urandom_range(0, 2),
                mk(op, $urandom_range(0, 19), $urandom_range(0, 6), $urandom_range(0, 15)),
                rb(), $urandom_range(0, 3));
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL random cyc%0d got %h expected %h", i, o, e); end
    end
  endtask

  // ------------------------------------------------ sequence + report
  initial begin
    rst = 1'b1; start = 1'b0; instr_valid = 1'b0; instr = '0; Z = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_move();
    test_alu();
    test_memory();
    test_jump();
    test_illegal_halt();
    test_random(150);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
